mac_dot_engine: RTL and testbench

Parametrised, pipelined signed multiply-accumulate engine for the MAC accelerator. It is the multi-lane successor to the single-lane MAC datapath under the `tt_um_` top. Each beat carries `LANES` operand pairs. Beats are accumulated into one dot product until a beat flagged `in_last` arrives. The result is then handed off through a valid/ready output register, with optional saturation.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_prod_sum.sv | 29 ++
 rtl/mac_dot_engine.sv | 143 ++++++++++++++
 tb/tb_mac_dot_engine.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC dot-product engine.
// Saturating accumulation is selected with the MAC_SAT_EN macro.
package mac_pkg;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_t;

  function automatic logic signed [63:0] acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Top two bits of the one-bit-wider sum disagree exactly on signed overflow.
  function automatic logic add_ovf(input logic [1:0] sum_top);
    return sum_top[1] ^ sum_top[0];
  endfunction

endpackage

// File: rtl/mac_prod_sum.sv
// Combinational per-lane signed multipliers plus the adder tree that sums them
// into one beat's partial sum.
module mac_prod_sum #(
  parameter int DATA_W = 8,
  parameter int LANES  = 2,
  parameter int PSUM_W = 2 * DATA_W + $clog2(LANES)
) (
  input  logic [LANES*DATA_W-1:0] a_i,
  input  logic [LANES*DATA_W-1:0] b_i,
  output logic [PSUM_W-1:0]       psum_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign prod[i] = PROD_W'($signed(a_i[i*DATA_W +: DATA_W])) *
                     PROD_W'($signed(b_i[i*DATA_W +: DATA_W]));
  end

  always_comb begin
    psum_o = '0;
    for (int i = 0; i < LANES; i++) begin
      psum_o = psum_o + PSUM_W'(prod[i]);
    end
  end

endmodule

// File: rtl/mac_dot_engine.sv
// Pipelined multi-lane signed dot-product engine: S1 partial-sum register,
// accumulator FSM and a valid/ready result register. MAC_SAT_EN selects saturation.
module mac_dot_engine
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 2,
  parameter int ACC_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_acc,
  output logic                    out_ovf,
  output logic                    busy
);

  localparam int PSUM_W = 2 * DATA_W + $clog2(LANES);

  if (ACC_W < PSUM_W + 1) begin : g_acc_w_check
    $error("mac_dot_engine: ACC_W too narrow for DATA_W/LANES");
  end

  // Handshake: a beat moves on in_valid && in_ready; a result moves on
  // out_valid && out_ready. Only a finished vector blocked by a full,
  // undrained output register stalls the pipe.
  logic                     stall, accept, beat;
  logic [PSUM_W-1:0]        psum_w;
  logic                     s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [PSUM_W-1:0] s1_psum_q, s1_psum_d;
  acc_state_t               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, out_acc_q, out_acc_d, psum_ext, beat_res;
  logic                     ovf_q, ovf_d, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  logic                     beat_ovf;
  logic [ACC_W:0]           sum_ext;

  mac_prod_sum #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .PSUM_W (PSUM_W)
  ) u_prod_sum (
    .a_i    (in_a),
    .b_i    (in_b),
    .psum_o (psum_w)
  );

  assign stall    = s1_valid_q && s1_last_q && out_valid_q && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && !stall;
  assign beat     = s1_valid_q && !stall;
  assign psum_ext = ACC_W'(s1_psum_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (beat) state_d = s1_last_q ? ACC_IDLE : ACC_RUN;
  end

  always_comb begin
    sum_ext  = {acc_q[ACC_W-1], acc_q} + {psum_ext[ACC_W-1], psum_ext};
    beat_ovf = 1'b0;
    beat_res = psum_ext;
    if (state_q == ACC_RUN) begin
      beat_ovf = add_ovf(sum_ext[ACC_W -: 2]);
`ifdef MAC_SAT_EN
      if (beat_ovf) beat_res = sum_ext[ACC_W] ? ACC_W'(acc_min(ACC_W)) : ACC_W'(acc_max(ACC_W));
      else          beat_res = sum_ext[ACC_W-1:0];
`else
      beat_res = sum_ext[ACC_W-1:0];
`endif
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_psum_d   = s1_psum_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_last_d = in_last;
        s1_psum_d = psum_w;
      end
    end
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    // A completing vector clears the accumulator so the next one starts clean.
    if (beat) begin
      if (s1_last_q) begin
        acc_d       = '0;
        ovf_d       = 1'b0;
        out_acc_d   = beat_res;
        out_ovf_d   = ovf_q | beat_ovf;
        out_valid_d = 1'b1;
      end else begin
        acc_d = beat_res;
        ovf_d = ovf_q | beat_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_psum_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_psum_q   <= s1_psum_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = s1_valid_q | (state_q == ACC_RUN) | out_valid_q;

endmodule

// File: tb/tb_mac_dot_engine.sv
// Bench for mac_dot_engine: a 24-bit and an 18-bit accumulator instance share
// one stimulus stream; results are checked against a queue-based scoreboard.
module tb_mac_dot_engine;

  localparam int DATA_W  = 8;
  localparam int LANES   = 2;
  localparam int ACC_W   = 24;
  localparam int ACC_W_S = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [LANES*DATA_W-1:0] in_a = '0;
  logic [LANES*DATA_W-1:0] in_b = '0;
  logic in_ready, out_valid, out_ovf, busy;
  logic signed [ACC_W-1:0] out_acc;
  logic in_ready_s, out_valid_s, out_ovf_s, busy_s;
  logic signed [ACC_W_S-1:0] out_acc_s;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [ACC_W-1:0]   exp_q[$];
  logic                      exp_ovf_q[$];
  logic signed [ACC_W_S-1:0] exp_s_q[$];
  logic                      exp_s_ovf_q[$];

  mac_dot_engine #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
  );

  mac_dot_engine #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W_S)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_acc(out_acc_s), .out_ovf(out_ovf_s), .busy(busy_s)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] pack(input int l0, input int l1);
    logic [7:0] x0, x1;
    x0 = l0[7:0];
    x1 = l1[7:0];
    return {x1, x0};
  endfunction

  function automatic longint psum_of(input logic [15:0] a, input logic [15:0] b);
    logic signed [7:0] a0, a1, b0, b1;
    longint p;
    a0 = a[7:0]; a1 = a[15:8]; b0 = b[7:0]; b1 = b[15:8];
    p = longint'(a0) * longint'(b0) + longint'(a1) * longint'(b1);
    return p;
  endfunction

  // Reference accumulate: exact sum, then wrap or clamp into w signed bits.
  function automatic longint acc_add(input int w, input longint acc, input longint p, output bit ov);
    longint mx, mn, s;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    s  = acc + p;
    ov = 1'b0;
    if (s > mx || s < mn) begin
      ov = 1'b1;
`ifdef MAC_SAT_EN
      s = (s > mx) ? mx : mn;
`else
      s = (s > mx) ? s - 2 * (mx + 1) : s + 2 * (mx + 1);
`endif
    end
    return s;
  endfunction

  function automatic void expect_res(input longint e, input bit o, input longint es, input bit os);
    exp_q.push_back(ACC_W'(e));
    exp_ovf_q.push_back(o);
    exp_s_q.push_back(ACC_W_S'(es));
    exp_s_ovf_q.push_back(os);
  endfunction

  // ---------------- scoreboard monitor ----------------
  bit held = 1'b0;
  logic signed [ACC_W-1:0] hold_acc;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_acc", out_acc, hold_acc);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got %0d expected none", out_acc);
        end else begin
          check("acc24", out_acc, exp_q.pop_front());
          check("ovf24", out_ovf, exp_ovf_q.pop_front());
          check("valid18", out_valid_s, 1);
          check("acc18", out_acc_s, exp_s_q.pop_front());
          check("ovf18", out_ovf_s, exp_s_ovf_q.pop_front());
        end
      end
      held     = out_valid && !out_ready;
      hold_acc = out_acc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    int budget;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    budget = 200;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int budget;
    in_valid = 1'b0;
    budget = 500;
    while ((exp_q.size() != 0 || busy) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    if (budget == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_acc"}, out_acc, 0);
    check({tag, "_out_ovf"}, out_ovf, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          beats;
    logic [15:0] a;
    logic [15:0] b;
    longint      exp24;
    bit          ovf24;
    longint      exp18;
    bit          ovf18;
  } vec_t;

  vec_t tbl[7];

  task automatic run_table();
`ifdef MAC_SAT_EN
    longint sat_hi = 131071, sat_lo = -131072;
`else
    longint sat_hi = -131072, sat_lo = 99584;
`endif
    tbl[0] = '{1, pack(3, 4),       pack(5, -2),       7,       0, 7,      0};
    tbl[1] = '{4, pack(-128, -128), pack(-128, -128),  131072,  0, sat_hi, 1};
    tbl[2] = '{1, pack(1, 1),       pack(1, 1),        2,       0, 2,      0};
    tbl[3] = '{1, pack(127, -128),  pack(127, -128),   32513,   0, 32513,  0};
    tbl[4] = '{2, pack(-128, -128), pack(-128, -128),  65536,   0, 65536,  0};
    tbl[5] = '{3, pack(-128, 127),  pack(127, 127),    -381,    0, -381,   0};
    tbl[6] = '{5, pack(-128, -128), pack(127, 127),    -162560, 0, sat_lo, 1};
    foreach (tbl[i]) expect_res(tbl[i].exp24, tbl[i].ovf24, tbl[i].exp18, tbl[i].ovf18);
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].beats; k++) send_beat(tbl[i].a, tbl[i].b, k == tbl[i].beats - 1);
    end
    wait_idle();
  endtask

  // ---------------- randomized vectors vs. reference model ----------------
  bit rand_done;

  task automatic run_random(input int n_vec);
    logic [15:0] av[6], bv[6];
    int nb;
    longint p, acc24, acc18;
    bit o24, o18, ov;
    for (int v = 0; v < n_vec; v++) begin
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        if (v % 4 == 3) begin
          av[k] = pack(-128, -128);
          bv[k] = ($urandom_range(0, 1) == 1) ? pack(-128, -128) : pack(127, 127);
        end else begin
          av[k] = 16'($urandom);
          bv[k] = 16'($urandom);
        end
        p = psum_of(av[k], bv[k]);
        if (k == 0) begin
          acc24 = p; acc18 = p; o24 = 1'b0; o18 = 1'b0;
        end else begin
          acc24 = acc_add(ACC_W, acc24, p, ov);   o24 |= ov;
          acc18 = acc_add(ACC_W_S, acc18, p, ov); o18 |= ov;
        end
      end
      expect_res(acc24, o24, acc18, o18);
      for (int k = 0; k < nb; k++) begin
        send_beat(av[k], bv[k], k == nb - 1);
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    check_reset_values("reset_in");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("reset_out");

    // Single-beat latency: result appears two edges after the beat is presented.
    expect_res(7, 0, 7, 0);
    send_beat(pack(3, 4), pack(5, -2), 1'b1);
    in_valid = 1'b0;
    check("lat_s1_valid", out_valid, 0);
    check("lat_s1_busy", busy, 1);
    @(posedge clk);
    #1;
    check("lat_out_valid", out_valid, 1);
    check("lat_out_acc", out_acc, 7);
    wait_idle();

    run_table();

    // Backpressure: second finished vector stalls behind an untaken result.
    out_ready = 1'b0;
    expect_res(7, 0, 7, 0);
    expect_res(2, 0, 2, 0);
    send_beat(pack(3, 4), pack(5, -2), 1'b1);
    send_beat(pack(1, 1), pack(1, 1), 1'b1);
    in_valid = 1'b0;
    check("bp_in_ready", in_ready, 0);
    check("bp_out_acc", out_acc, 7);
    repeat (3) @(posedge clk);
    #1;
    check("bp_still_stalled", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_acc", out_acc, 2);
    check("bp_released", in_ready, 1);
    wait_idle();

    // Reset in the middle of an open vector discards it.
    for (int k = 0; k < 3; k++) send_beat(pack(5, 5), pack(5, 5), 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_res(9, 0, 9, 0);
    send_beat(pack(1, 0), pack(9, 0), 1'b1);
    wait_idle();

    // Random traffic with random consumer backpressure.
    rand_done = 1'b0;
    fork
      begin
        run_random(40);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();

    check("final_queue_empty", exp_q.size(), 0);
    check("final_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
